// File: rtl/vga_scan_compositor_if.sv
// Scan/pixel bundle between the compositor (master) and the layers/VGA pins (slave).
// Carries layer palette indices in and scan counters, syncs, rgb and status pulses out.
interface vga_scan_compositor_if #(
    parameter int CIDXW = 3,
    parameter int CORDW = 10
);
    logic [CIDXW:0]   level_pix;
    logic [CIDXW:0]   obstacle_pix;
    logic [CIDXW:0]   player_pix;
    logic [CORDW-1:0] hc;
    logic [CORDW-1:0] vc;
    logic             line;
    logic             hSync;
    logic             vSync;
    logic [7:0]       rgb;
    logic             frame_end;
    logic             collision;

    modport master (
        input  level_pix, obstacle_pix, player_pix,
        output hc, vc, line, hSync, vSync, rgb, frame_end, collision
    );

    modport slave (
        output level_pix, obstacle_pix, player_pix,
        input  hc, vc, line, hSync, vSync, rgb, frame_end, collision
    );
endinterface

// File: rtl/vga_scan_compositor.sv
// 640x480@60 scan generator + 3-layer priority compositor; optional collision flag under COLLISION_DETECT_EN.
// Latency: syncs move with hc/vc; rgb updates 2 CLK after its hc/vc (phase 2 of the same pixel).
// Backpressure: none -- free-running scan, layers must present indices by phase 2.
module vga_scan_compositor #(
    parameter int         CIDXW    = 3,
    parameter int         CORDW    = 10,
    parameter int         H_TOTAL  = 800,
    parameter int         V_TOTAL  = 525,
    parameter int         H_SYNC   = 96,
    parameter int         V_SYNC   = 2,
    parameter int         H_VIS_LO = 144,
    parameter int         V_VIS_LO = 35,
    parameter int         H_VIS_W  = 640,
    parameter int         V_VIS_H  = 480,
    parameter logic [7:0] BG_RGB   = 8'h00
) (
    input logic                   CLK,
    input logic                   RESET,
    vga_scan_compositor_if.master vga
);

    localparam logic [CORDW-1:0] H_LAST    = CORDW'(H_TOTAL - 1);
    localparam logic [CORDW-1:0] V_LAST    = CORDW'(V_TOTAL - 1);
    localparam logic [CORDW-1:0] H_SYNC_E  = CORDW'(H_SYNC);
    localparam logic [CORDW-1:0] V_SYNC_E  = CORDW'(V_SYNC);
    localparam logic [CORDW-1:0] H_VIS_B   = CORDW'(H_VIS_LO);
    localparam logic [CORDW-1:0] H_VIS_E   = CORDW'(H_VIS_LO + H_VIS_W);
    localparam logic [CORDW-1:0] V_VIS_B   = CORDW'(V_VIS_LO);
    localparam logic [CORDW-1:0] V_VIS_E   = CORDW'(V_VIS_LO + V_VIS_H);

    logic [1:0]       phase;
    logic [CORDW-1:0] hc_q, vc_q, hc_nxt, vc_nxt;
    logic             line_q, frame_end_q, hsync_q, vsync_q;
    logic [7:0]       rgb_q, pix_rgb;
    logic             px_end, hc_wrap, vc_wrap, frame_wrap, sample, visible;

    function automatic logic [7:0] pal(input logic [3:0] idx);
        case (idx)
            4'd0:    pal = BG_RGB;
            4'd1:    pal = 8'h49;
            4'd2:    pal = 8'hE0;
            4'd3:    pal = 8'h1C;
            4'd4:    pal = 8'h03;
            4'd5:    pal = 8'hFC;
            4'd6:    pal = 8'hE3;
            4'd7:    pal = 8'hFF;
            4'd8:    pal = 8'hF0;
            default: pal = 8'h92;
        endcase
    endfunction

    assign px_end     = (phase == 2'd3);
    assign hc_wrap    = (hc_q == H_LAST);
    assign vc_wrap    = (vc_q == V_LAST);
    assign frame_wrap = px_end && hc_wrap && vc_wrap;
    // Layers register one CLK after hc/vc move, so their indices are settled by the phase 1->2 edge.
    assign sample     = (phase == 2'd1);
    assign visible    = (hc_q >= H_VIS_B) && (hc_q < H_VIS_E) &&
                        (vc_q >= V_VIS_B) && (vc_q < V_VIS_E);

    always_comb begin
        hc_nxt = hc_q;
        vc_nxt = vc_q;
        if (px_end) begin
            hc_nxt = hc_wrap ? '0 : hc_q + CORDW'(1);
            if (hc_wrap) begin
                vc_nxt = vc_wrap ? '0 : vc_q + CORDW'(1);
            end
        end
    end

    always_comb begin
        pix_rgb = BG_RGB;
        if (!visible) begin
            pix_rgb = 8'h00;
        end else if (|vga.player_pix) begin
            pix_rgb = pal(vga.player_pix[3:0]);
        end else if (|vga.obstacle_pix) begin
            pix_rgb = pal(vga.obstacle_pix[3:0]);
        end else if (|vga.level_pix) begin
            pix_rgb = pal(vga.level_pix[3:0]);
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            phase       <= 2'd0;
            hc_q        <= '0;
            vc_q        <= '0;
            line_q      <= 1'b0;
            frame_end_q <= 1'b0;
            hsync_q     <= 1'b1;
            vsync_q     <= 1'b1;
            rgb_q       <= 8'h00;
        end else begin
            phase       <= phase + 2'd1;
            hc_q        <= hc_nxt;
            vc_q        <= vc_nxt;
            line_q      <= px_end && hc_wrap;
            frame_end_q <= frame_wrap;
            hsync_q     <= !(hc_nxt < H_SYNC_E);
            vsync_q     <= !(vc_nxt < V_SYNC_E);
            if (sample) begin
                rgb_q <= pix_rgb;
            end
        end
    end

`ifdef COLLISION_DETECT_EN
    logic hit_flag, collision_q, hit_now;

    assign hit_now = sample && visible && (|vga.player_pix) && (|vga.obstacle_pix);

    // Result for a frame is published at its frame_end and held for the whole next frame.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            hit_flag    <= 1'b0;
            collision_q <= 1'b0;
        end else if (frame_wrap) begin
            collision_q <= hit_flag | hit_now;
            hit_flag    <= 1'b0;
        end else if (hit_now) begin
            hit_flag    <= 1'b1;
        end
    end

    assign vga.collision = collision_q;
`else
    assign vga.collision = 1'b0;
`endif

    assign vga.hc        = hc_q;
    assign vga.vc        = vc_q;
    assign vga.line      = line_q;
    assign vga.frame_end = frame_end_q;
    assign vga.hSync     = hsync_q;
    assign vga.vSync     = vsync_q;
    assign vga.rgb       = rgb_q;

endmodule

// File: tb/tb_vga_scan_compositor.sv
// Bench for vga_scan_compositor on a shrunken raster (40x12 total, 24x6 visible) so several frames fit.
// A cycle-count model predicts every output; literal spot values pin the model.
module tb_vga_scan_compositor;

    localparam int HT = 40, VT = 12, HS = 4, VS = 2;
    localparam int HL = 8, VL = 3, HW = 24, VH = 6;
    localparam logic [7:0] BG = 8'h25;
    localparam int FPIX = HT * VT;

    logic CLK = 1'b0;
    logic RESET = 1'b1;

    vga_scan_compositor_if #(.CIDXW(3), .CORDW(10)) vif ();

    vga_scan_compositor #(
        .CIDXW(3), .CORDW(10), .H_TOTAL(HT), .V_TOTAL(VT), .H_SYNC(HS), .V_SYNC(VS),
        .H_VIS_LO(HL), .V_VIS_LO(VL), .H_VIS_W(HW), .V_VIS_H(VH), .BG_RGB(BG)
    ) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .vga   (vif.master)
    );

    always #5 CLK = ~CLK;

    int         t;
    int         nchk = 0;
    int         errs = 0;
    logic [7:0] pix_rgb [0:8191];
    bit         hit [0:7];
    bit         chk_en = 1'b0;
    bit         first_run = 1'b1;
    int         line_t [0:1];
    int         fe_t [0:1];
    int         nline = 0, nfe = 0, hs_low = 0, vs_low = 0;
    logic [4:0] ec;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h (t=%0d)", nm, act, exp, t);
        end
    endtask

    function automatic logic [7:0] pal(input logic [3:0] i);
        logic [7:0] c;
        if (i == 0)      c = BG;
        else if (i >= 9) c = 8'h92;
        else begin
            case (i)
                4'd1: c = 8'h49;  4'd2: c = 8'hE0;  4'd3: c = 8'h1C;  4'd4: c = 8'h03;
                4'd5: c = 8'hFC;  4'd6: c = 8'hE3;  4'd7: c = 8'hFF;  default: c = 8'hF0;
            endcase
        end
        return c;
    endfunction

    function automatic bit is_vis(input int h, input int v);
        return (h >= HL) && (h < HL + HW) && (v >= VL) && (v < VL + VH);
    endfunction

    // Directed scene per frame: returns {player, obstacle, level}.
    function automatic logic [11:0] scene(input int f, input int h, input int v);
        logic [3:0] lv, ob, pl;
        lv = 0; ob = 0; pl = 0;
        case (f)
            0: begin
                if (h >= 10 && h <= 25) lv = 7;
                if (h >= 15 && h <= 24 && v >= 4 && v <= 6) ob = 8;
                if (h >= 18 && h <= 21 && v == 5) pl = 2;
                if (v == 7) pl = 4'(h);
            end
            1: if (!is_vis(h, v)) begin lv = 7; ob = 7; pl = 7; end
            2: begin
                if (h == 31 && v == 8) begin pl = 1; ob = 1; end
                if (h == 8 && v == 3) lv = 3;
            end
            3: if ((h == 32 && v == 8) || (h == 31 && v == 9)) begin pl = 1; ob = 1; end
            4: lv = 5;
            default: ;
        endcase
        return {pl, ob, lv};
    endfunction

    function automatic int tgt(input int f, input int h, input int v, input int ph);
        return ((f * FPIX + v * HT + h) * 4) + ph;
    endfunction

    // Layer driver: t counts CLK edges since reset release; layers present a pixel one CLK after hc moves.
    initial begin : driver
        int p, f, h, v;
        logic [11:0] s;
        t = 0;
        forever begin
            @(posedge CLK);
            #1;
            if (RESET) begin
                t = 0;
                foreach (hit[i]) hit[i] = 1'b0;
                vif.level_pix = 0; vif.obstacle_pix = 0; vif.player_pix = 0;
            end else begin
                t++;
                if (t % 4 == 1) begin
                    p = t / 4; f = p / FPIX; h = p % HT; v = (p / HT) % VT;
                    s = scene(f, h, v);
                    vif.level_pix = s[3:0]; vif.obstacle_pix = s[7:4]; vif.player_pix = s[11:8];
                    if (!is_vis(h, v))        pix_rgb[p] = 8'h00;
                    else if (s[11:8] != 0)    pix_rgb[p] = pal(s[11:8]);
                    else if (s[7:4] != 0)     pix_rgb[p] = pal(s[7:4]);
                    else if (s[3:0] != 0)     pix_rgb[p] = pal(s[3:0]);
                    else                      pix_rgb[p] = BG;
                    if (is_vis(h, v) && s[11:8] != 0 && s[7:4] != 0) hit[f] = 1'b1;
                end
            end
        end
    end

    // Per-cycle compare against the cycle-count model.
    always @(negedge CLK) begin : compare
        int p, ph, h, v, f;
        logic [7:0] e_rgb;
        logic e_line, e_fe, e_col;
        if (chk_en && !RESET) begin
            p = t / 4; ph = t % 4; h = p % HT; v = (p / HT) % VT; f = p / FPIX;
            e_rgb  = (ph >= 2) ? pix_rgb[p] : ((p >= 1) ? pix_rgb[p-1] : 8'h00);
            e_line = (t > 0) && (ph == 0) && (h == 0);
            e_fe   = e_line && (v == 0);
`ifdef COLLISION_DETECT_EN
            e_col  = (f > 0) ? hit[f-1] : 1'b0;
`else
            e_col  = 1'b0;
`endif
            chk("hc", vif.hc, h);
            chk("vc", vif.vc, v);
            chk("line", vif.line, e_line);
            chk("frame_end", vif.frame_end, e_fe);
            chk("hSync", vif.hSync, (t == 0) ? 1 : (h >= HS));
            chk("vSync", vif.vSync, (t == 0) ? 1 : (v >= VS));
            chk("rgb", vif.rgb, e_rgb);
            chk("collision", vif.collision, e_col);
            if (vif.line) begin
                if (nline < 2) line_t[nline] = t;
                nline++;
            end
            if (vif.frame_end) begin
                if (nfe < 2) fe_t[nfe] = t;
                nfe++;
            end
            if (first_run && !vif.hSync && t >= 160 && t < 320) hs_low++;
            if (first_run && !vif.vSync && t >= 1920 && t < 3840) vs_low++;
        end
    end

    task automatic wait_t(input int target);
        int n = 0;
        while (t != target && n < 20000) begin
            @(posedge CLK);
            #2;
            n++;
        end
        if (t != target) begin
            nchk++; errs++;
            $display("FAIL wait_t: t=%0d never reached %0d", t, target);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_hc"}, vif.hc, 0);
        chk({tag, "_vc"}, vif.vc, 0);
        chk({tag, "_line"}, vif.line, 0);
        chk({tag, "_hSync"}, vif.hSync, 1);
        chk({tag, "_vSync"}, vif.vSync, 1);
        chk({tag, "_rgb"}, vif.rgb, 0);
        chk({tag, "_frame_end"}, vif.frame_end, 0);
        chk({tag, "_collision"}, vif.collision, 0);
    endtask

    initial begin
`ifdef COLLISION_DETECT_EN
        ec = 5'b01010;
`else
        ec = 5'b00000;
`endif
        vif.level_pix = 0; vif.obstacle_pix = 0; vif.player_pix = 0;
        RESET = 1'b1;
        repeat (3) @(posedge CLK);
        #2;
        chk_reset_vals("rst0");
        #1;
        RESET = 1'b0;
        chk_en = 1'b1;

        wait_t(tgt(0, 16, 5, 3));  chk("prio_obstacle", vif.rgb, 8'hF0);
        wait_t(tgt(0, 18, 5, 3));  chk("prio_player", vif.rgb, 8'hE0);
        wait_t(tgt(0, 12, 7, 3));  chk("pal_grey", vif.rgb, 8'h92);
        wait_t(tgt(0, 20, 7, 2));  chk("pal_4", vif.rgb, 8'h03);
        wait_t(tgt(1, 8, 3, 3));   chk("bg_first_vis", vif.rgb, BG);
        chk("coll_f1", vif.collision, ec[1]);
        wait_t(tgt(1, 5, 5, 3));   chk("hblank_all7", vif.rgb, 8'h00);
        wait_t(tgt(1, 20, 10, 3)); chk("vblank_all7", vif.rgb, 8'h00);
        wait_t(tgt(2, 8, 3, 3));   chk("lvl_first_vis", vif.rgb, 8'h1C);
        chk("coll_f2", vif.collision, ec[2]);
        wait_t(tgt(2, 31, 8, 3));  chk("last_vis_pix", vif.rgb, 8'h49);
        wait_t(tgt(3, 31, 9, 3));  chk("row_after_vis", vif.rgb, 8'h00);
        chk("coll_f3", vif.collision, ec[3]);
        wait_t(tgt(3, 32, 9, 3));  chk("col_after_vis", vif.rgb, 8'h00);
        wait_t(tgt(4, 10, 4, 3));  chk("lvl_5", vif.rgb, 8'hFC);
        chk("coll_f4", vif.collision, ec[4]);

        // Mid-frame reset held across 3 CLK edges.
        wait_t(tgt(4, 20, 6, 1));
        RESET = 1'b1;
        first_run = 1'b0;
        #1;
        chk_reset_vals("rst_mid");
        for (int k = 0; k < 3; k++) begin
            @(posedge CLK);
            #2;
            chk("rst_hold_hc", vif.hc, 0);
        end
        #1;
        RESET = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            @(posedge CLK);
            #2;
            chk("restart_hc", vif.hc, (k == 4) ? 1 : 0);
        end
        wait_t(tgt(1, 10, 5, 0));
        chk("coll_after_rst", vif.collision, ec[1]);

        chk("line_first_t", line_t[0], 160);
        chk("line_period", line_t[1] - line_t[0], 160);
        chk("fe_first_t", fe_t[0], 1920);
        chk("fe_period", fe_t[1] - fe_t[0], 1920);
        chk("hsync_low_clks", hs_low, 16);
        chk("vsync_low_clks", vs_low, 320);

        $display("End of test - %0d assertions evaluated, %0d failures", nchk, errs);
        $finish;
    end

endmodule
